// File: rtl/sign_mag_conv_pipe.sv
// rtl/sign_mag_conv_pipe.sv - two-stage two's-complement <-> sign-magnitude converter
// Valid/ready handshake on both sides, leading-zero count and saturation counter.
module sign_mag_conv_pipe #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 16,
  localparam int LZ_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sign,
  output logic [LZ_W-1:0]  out_lz,
  output logic             out_sat,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_cnt
);

  logic             v1;
  logic             v2;
  logic [WIDTH-1:0] d1;
  logic             m1;
  logic             adv2;

  logic             s1_sign;
  logic             s1_sat;
  logic [WIDTH-2:0] s1_mag;
  logic [WIDTH-2:0] s1_neg_mag;
  logic [WIDTH-1:0] s2_res;
  logic [LZ_W-1:0]  s2_lz;

  function automatic logic [LZ_W-1:0] lz_count(input logic [WIDTH-2:0] m);
    lz_count = LZ_W'(WIDTH - 1);
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (m[i]) lz_count = LZ_W'(WIDTH - 2 - i);
    end
  endfunction

  // Stage 2 advances whenever its slot is free or being emptied downstream.
  assign adv2      = !v2 || out_ready;
  assign in_ready  = !v1 || adv2;
  assign out_valid = v2;

  always_comb begin
    s1_sign    = d1[WIDTH-1];
    s1_sat     = 1'b0;
    s1_neg_mag = (~d1[WIDTH-2:0]) + 1'b1;
    s1_mag     = d1[WIDTH-2:0];
    if (!m1 && s1_sign) begin
      // The most-negative value has no magnitude in WIDTH-1 bits; clamp it.
      if (d1[WIDTH-2:0] == '0) begin
        s1_sat = 1'b1;
        s1_mag = '1;
      end else begin
        s1_mag = s1_neg_mag;
      end
    end
  end

  always_comb begin
    s2_lz = lz_count(s1_mag);
    if (!m1) begin
      s2_res = {s1_sign, s1_mag};
    end else if (s1_sign) begin
      s2_res = (~{1'b0, s1_mag}) + 1'b1;
    end else begin
      s2_res = {1'b0, s1_mag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      d1 <= '0;
      m1 <= 1'b0;
    end else if (in_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        d1 <= in_data;
        m1 <= in_mode;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2       <= 1'b0;
      out_data <= '0;
      out_sign <= 1'b0;
      out_lz   <= '0;
      out_sat  <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        out_data <= s2_res;
        out_sign <= s2_res[WIDTH-1];
        out_lz   <= s2_lz;
        out_sat  <= s1_sat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (v2 && out_ready && out_sat && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sign_mag_conv_pipe.sv
// tb/tb_sign_mag_conv_pipe.sv - scoreboard bench for sign_mag_conv_pipe
// A second instance with CNT_W=2 shares all inputs to exercise counter saturation.
module tb_sign_mag_conv_pipe;

  typedef struct packed {
    logic [11:0] data;
    logic        sign;
    logic [3:0]  lz;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_mode = 1'b0;
  logic        out_ready = 1'b1;
  logic        sat_clr = 1'b0;
  logic        in_ready, out_valid, out_sign, out_sat;
  logic [11:0] out_data;
  logic [3:0]  out_lz;
  logic [15:0] sat_cnt;
  logic        in_ready2, out_valid2, out_sign2, out_sat2;
  logic [11:0] out_data2;
  logic [3:0]  out_lz2;
  logic [1:0]  sat_cnt2;

  exp_t sb[$];
  int   checks = 0;
  int   errs = 0;
  int   n_del = 0;
  int   m_cnt = 0;
  int   m_cnt2 = 0;
  bit   rand_rdy = 1'b0;
  bit   saw_block = 1'b0;

  sign_mag_conv_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sign(out_sign),
    .out_lz(out_lz), .out_sat(out_sat), .sat_clr(sat_clr), .sat_cnt(sat_cnt)
  );

  sign_mag_conv_pipe #(.WIDTH(12), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_sign(out_sign2),
    .out_lz(out_lz2), .out_sat(out_sat2), .sat_clr(sat_clr), .sat_cnt(sat_cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [11:0] d, input logic m);
    exp_t e;
    int   val;
    int   mag;
    e.sat = 1'b0;
    if (!m) begin
      val = d[11] ? int'(d) - 4096 : int'(d);
      if (val == -2048) begin
        e.sat = 1'b1;
        mag = 2047;
        e.data = 12'hFFF;
      end else begin
        mag = (val < 0) ? -val : val;
        e.data = {d[11], mag[10:0]};
      end
    end else begin
      mag = int'(d[10:0]);
      val = d[11] ? -mag : mag;
      e.data = val[11:0];
    end
    e.sign = e.data[11];
    e.lz = 4'd11;
    for (int b = 0; b < 11; b++) if (mag[b]) e.lz = 4'(10 - b);
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the sample is accepted.
  task automatic send(input logic [11:0] d, input logic m, input exp_t e);
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_mode = m;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    else sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1 check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: sampled on the falling edge, a handshake seen here completes on the next rising edge.
  initial begin
    exp_t e;
    exp_t held;
    bit   hold_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_chk = 1'b0;
      end else begin
        if (hold_chk) check("stall_hold", 32'({out_data, out_sign, out_lz, out_sat}), 32'(held));
        hold_chk = out_valid && !out_ready;
        held = {out_data, out_sign, out_lz, out_sat};
        if (in_valid && !in_ready && !out_ready) saw_block = 1'b1;
        check("sat_cnt", 32'(sat_cnt), 32'(m_cnt));
        check("sat_cnt_w2", 32'(sat_cnt2), 32'(m_cnt2));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("spurious_out", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_sign", 32'(out_sign), 32'(e.sign));
            check("out_lz", 32'(out_lz), 32'(e.lz));
            check("out_sat", 32'(out_sat), 32'(e.sat));
            n_del++;
            if (out_sat && m_cnt < 65535) m_cnt++;
            if (out_sat && m_cnt2 < 3) m_cnt2++;
          end
        end
        if (sat_clr) begin
          m_cnt = 0;
          m_cnt2 = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [11:0] bp_d [6] = '{12'h123, 12'h8FF, 12'h800, 12'h000, 12'hF00, 12'h7FF};
    logic        bp_m [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int          ref_cnt2 [5] = '{1, 2, 3, 3, 3};
    logic [11:0] d;
    logic        m;
    int          base;

    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors with hand-computed results.
    send(12'hFFF, 1'b0, '{12'h801, 1'b1, 4'd10, 1'b0});
    send(12'h800, 1'b0, '{12'hFFF, 1'b1, 4'd0, 1'b1});
    send(12'h805, 1'b1, '{12'hFFB, 1'b1, 4'd8, 1'b0});
    send(12'h800, 1'b1, '{12'h000, 1'b0, 4'd11, 1'b0});
    send(12'h07F, 1'b1, '{12'h07F, 1'b0, 4'd4, 1'b0});
    drain();
    check("sat_cnt_after_one", 32'(sat_cnt), 32'd1);

    // Saturating delivery on the same edge as sat_clr: clear wins.
    send(12'h800, 1'b0, '{12'hFFF, 1'b1, 4'd0, 1'b1});
    @(posedge clk);
    #1 sat_clr = 1'b1;
    @(posedge clk);
    #1 sat_clr = 1'b0;
    check("sat_clr_priority", 32'(sat_cnt), 32'd0);
    drain();

    for (int i = 0; i < 5; i++) begin
      send(12'h800, 1'b0, model(12'h800, 1'b0));
      repeat (3) @(posedge clk);
      #1;
      check("cnt2_seq", 32'(sat_cnt2), 32'(ref_cnt2[i]));
      check("cnt16_seq", 32'(sat_cnt), 32'(i + 1));
    end

    // Backpressure: out_ready low for three cycles mid-stream.
    base = n_del;
    saw_block = 1'b0;
    fork
      for (int i = 0; i < 6; i++) send(bp_d[i], bp_m[i], model(bp_d[i], bp_m[i]));
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_in_ready_drop", 32'(saw_block), 32'd1);
    check("bp_delivered", 32'(n_del - base), 32'd6);

    // Random samples under random backpressure.
    base = n_del;
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      d = 12'($urandom);
      if (i % 7 == 0) d = 12'h800;
      m = 1'($urandom_range(0, 1));
      send(d, m, model(d, m));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain();
    check("rand_delivered", 32'(n_del - base), 32'd60);

    // Asynchronous reset with both stages full.
    send(12'h800, 1'b0, model(12'h800, 1'b0));
    drain();
    out_ready = 1'b0;
    send(12'h234, 1'b0, model(12'h234, 1'b0));
    send(12'h9AB, 1'b1, model(12'h9AB, 1'b1));
    check("pre_rst_full", 32'(out_valid && !in_ready), 32'd1);
    check("pre_rst_cnt_nz", 32'(sat_cnt != 0), 32'd1);
    #2 rst = 1'b1;
    sb.delete();
    m_cnt = 0;
    m_cnt2 = 0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_sat_cnt", 32'(sat_cnt), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    base = n_del;
    send(12'hFFE, 1'b0, '{12'h802, 1'b1, 4'd9, 1'b0});
    drain();
    check("post_rst_delivered", 32'(n_del - base), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sign_mag_conv_pipe.md
# sign_mag_conv_pipe

Parametrised, pipelined converter between two's-complement and sign-magnitude. It is the streaming successor of the 12-bit combinational converter in the linear-to-floating-point datapath. It converts in either direction, selected per sample. It saturates the unrepresentable most-negative value, reports the leading-zero count of the magnitude for the downstream exponent/mantissa encoder, and counts saturation events. Valid/ready handshakes on both sides allow it to sit between the sample source and the FP encoder.

## Interface
Parameters:
- WIDTH, 12, sample width including sign bit; legal range is 4 or more.
- CNT_W, 16, width of the saturation event counter.
- LZ_W, clog2(WIDTH), derived localparam; width of the leading-zero count.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  WIDTH  input sample.
- in_mode  in  1  0 = two's-complement to sign-magnitude; 1 = sign-magnitude to two's-complement. Sampled with in_data.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  converted sample.
- out_sign  out  1  sign of the result.
- out_lz  out  LZ_W  leading zeros in the WIDTH-1-bit magnitude, 0..WIDTH-1.
- out_sat  out  1  result was saturated.
- sat_clr  in  1  synchronous clear of sat_cnt.
- sat_cnt  out  CNT_W  saturating count of delivered results with out_sat=1.

## Operation
- A sample is accepted on an edge where in_valid && in_ready. A result is delivered on an edge where out_valid && out_ready.
- Mode 0 (two's-complement to sign-magnitude), input D:
  - Sign s = D[W-1].
  - Magnitude m = D[W-2:0] if s=0, else (-D) truncated to W-1 bits.
  - For D = 100…0: m = all ones (2^(W-1)-1), out_sat=1, out_data = {1, all ones}.
  - Otherwise out_data = {s, m} and out_sat=0.
- Mode 1 (sign-magnitude to two's-complement), input {s, m}:
  - If s=0, out_data = {0, m}.
  - If s=1, out_data = two's-complement negation of the zero-extended m.
  - Negative zero 100…0 maps to 0 with out_sign=0.
  - out_sat is always 0 in this mode.
- out_lz is the count of leading zeros of m (the magnitude used above); m=0 gives WIDTH-1.
- out_sign = out_data[W-1].
- Pipeline:
  - Stage 1 registers the sample and mode, and computes the sign, magnitude and sat flag.
  - Stage 2 computes the leading-zero count and the final out_data, and holds the output registers.
- Stall rules:
  - Stage k may load when it is empty or stage k+1 is loading; stage 2 is unloaded when out_ready is high.
  - in_ready = !v1 || !v2 || out_ready.
  - Full throughput is one sample per cycle.
- sat_cnt:
  - Increments by 1 on each delivery with out_sat=1 and saturates at 2^CNT_W-1.
  - sat_clr has priority: with sat_clr=1, sat_cnt becomes 0 on that edge, even if a saturating delivery happens on the same edge.

## Timing
- Latency is 2 edges: a sample accepted at edge k drives out_valid=1 after edge k+1.
- While out_valid && !out_ready: out_data, out_sign, out_lz and out_sat hold stable, and stage 1 holds if it is full.
- Accept and deliver on the same edge are legal. With both stages full and out_ready=1, in_ready=1 and the pipeline shifts.
- in_ready depends combinationally on out_ready. There is no combinational path from in_data to the outputs.
- Reset, asynchronous, takes effect immediately, including mid-stream:
  - Stage valids, out_valid, out_data, out_sign, out_lz, out_sat and sat_cnt all go to 0.
  - In-flight samples are discarded.
  - in_ready reads 1 while reset is held and after release.
- Order is preserved; no sample is dropped or duplicated under any out_ready pattern.

## Test plan
- WIDTH=12, mode 0, D=12'hFFF -> 2 cycles later out_data=12'h801, out_sign=1, out_lz=10, out_sat=0.
- Mode 0, D=12'h800 -> out_data=12'hFFF, out_sat=1, out_lz=0; after delivery sat_cnt=1. A second run of this case with sat_clr=1 on the delivery edge gives sat_cnt=0.
- Mode 1:
  - 12'h805 -> out_data=12'hFFB, out_sign=1, out_lz=8.
  - 12'h800 -> out_data=12'h000, out_sign=0, out_lz=11.
  - 12'h07F -> out_data=12'h07F, out_lz=4.
- Backpressure: stream 6 mixed-mode samples with out_ready low for cycles 3-5 -> in_ready drops after 2 samples are held; all 6 results are delivered in order with no loss or duplication; outputs are stable during the stall.
- Reset mid-stream with both stages full -> out_valid=0 and sat_cnt=0 immediately, without waiting for a clock edge; the first result after reset is the first sample accepted after reset.
- CNT_W=2, 5 saturating deliveries -> sat_cnt reads 1, 2, 3, 3, 3.
